// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit MEM-stage loads/stores to a 16-bit
// asynchronous SRAM. Each word access is two half-word phases (low half, then
// high half). Each phase is held for WAIT_CYCLES+1 cycles, and a one-cycle
// DONE state follows that pulses `ready`.
//
// Optional feature: define SRAM_READ_BUF_EN to add a one-entry read buffer
// {valid, word, data}. A load that hits the buffer skips both SRAM phases.
// Without the macro, every access runs the full LOW/HIGH sequence.
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] st_value,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE_ADDR = 32'(ADDR_BASE);
  localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYCLES);

  state_t      state_reg;
  logic [2:0]  wc_reg;
  logic        is_write_reg;
  logic [16:0] word_reg;
  logic [15:0] st_hi_reg;

  logic [31:0] read_data_reg;
  logic        ready_reg;
  logic [17:0] sram_addr_reg;
  logic [15:0] sram_dq_out_reg;
  logic        sram_dq_oe_reg;
  logic        sram_we_n_reg;

  // Word index of the incoming request. Offsets below the base wrap modulo
  // 2^17 words, and the byte-lane bits are ignored.
  logic [31:0] offset_next;
  logic [16:0] word_next;
  logic        unused_offset_bits;

  assign offset_next        = address - BASE_ADDR;
  assign word_next          = offset_next[18:2];
  assign unused_offset_bits = ^{offset_next[31:19], offset_next[1:0]};

`ifdef SRAM_READ_BUF_EN
  logic        buf_valid_reg;
  logic [16:0] buf_word_reg;
  logic [31:0] buf_data_reg;
  logic        buf_match;

  // The buffered word matches the incoming request.
  assign buf_match = buf_valid_reg && (buf_word_reg == word_next);
`endif

  // Stall the pipeline while a request is pending and not yet completed.
  assign freeze = (mem_r_en | mem_w_en) & ~ready_reg;

  assign read_data   = read_data_reg;
  assign ready       = ready_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_dq_out = sram_dq_out_reg;
  assign sram_dq_oe  = sram_dq_oe_reg;
  assign sram_we_n   = sram_we_n_reg;

  // Access sequencer: IDLE -> LOW -> HIGH -> DONE. All SRAM-side outputs are
  // registered so they stay stable for a whole phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      wc_reg          <= '0;
      is_write_reg    <= 1'b0;
      word_reg        <= '0;
      st_hi_reg       <= '0;
      read_data_reg   <= '0;
      ready_reg       <= 1'b0;
      sram_addr_reg   <= '0;
      sram_dq_out_reg <= '0;
      sram_dq_oe_reg  <= 1'b0;
      sram_we_n_reg   <= 1'b1;
`ifdef SRAM_READ_BUF_EN
      buf_valid_reg   <= 1'b0;
      buf_word_reg    <= '0;
      buf_data_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          wc_reg <= '0;
          if (mem_w_en) begin
            // A store wins when both enables are high.
            state_reg       <= LOW;
            is_write_reg    <= 1'b1;
            word_reg        <= word_next;
            st_hi_reg       <= st_value[31:16];
            sram_addr_reg   <= {word_next, 1'b0};
            sram_dq_out_reg <= st_value[15:0];
            sram_dq_oe_reg  <= 1'b1;
            sram_we_n_reg   <= 1'b0;
`ifdef SRAM_READ_BUF_EN
            // Keep the buffer coherent with the word being stored.
            if (buf_match) begin
              buf_data_reg <= st_value;
            end
`endif
          end else if (mem_r_en) begin
`ifdef SRAM_READ_BUF_EN
            if (buf_match) begin
              // Buffer hit: answer without touching the SRAM.
              state_reg     <= DONE;
              ready_reg     <= 1'b1;
              read_data_reg <= buf_data_reg;
            end else begin
`else
            begin
`endif
              state_reg      <= LOW;
              is_write_reg   <= 1'b0;
              word_reg       <= word_next;
              sram_addr_reg  <= {word_next, 1'b0};
              sram_dq_oe_reg <= 1'b0;
              sram_we_n_reg  <= 1'b1;
            end
          end
        end

        LOW: begin
          if (wc_reg == WAIT_LAST) begin
            wc_reg          <= '0;
            state_reg       <= HIGH;
            sram_addr_reg   <= {word_reg, 1'b1};
            sram_dq_out_reg <= st_hi_reg;
            if (!is_write_reg) begin
              read_data_reg[15:0] <= sram_dq_in;
            end
          end else begin
            wc_reg <= wc_reg + 3'd1;
          end
        end

        HIGH: begin
          if (wc_reg == WAIT_LAST) begin
            wc_reg         <= '0;
            state_reg      <= DONE;
            ready_reg      <= 1'b1;
            sram_dq_oe_reg <= 1'b0;
            sram_we_n_reg  <= 1'b1;
            if (!is_write_reg) begin
              read_data_reg[31:16] <= sram_dq_in;
`ifdef SRAM_READ_BUF_EN
              buf_valid_reg <= 1'b1;
              buf_word_reg  <= word_reg;
              buf_data_reg  <= {sram_dq_in, read_data_reg[15:0]};
`endif
            end
          end else begin
            wc_reg <= wc_reg + 3'd1;
          end
        end

        DONE: begin
          // The pipeline advances on the edge that ends this cycle.
          ready_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed testbench for sram_controller. It uses two instances: one with the
// default 2 wait states and one with 0 wait states. Each instance drives its
// own behavioural asynchronous SRAM model.
module tb_sram_controller;

  logic        clock = 1'b0;
  logic        reset;

  // W=2 instance
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, st_value, read_data;
  logic        ready, freeze, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  // W=0 instance
  logic        mem_r_en0, mem_w_en0;
  logic [31:0] address0, st_value0, read_data0;
  logic        ready0, freeze0, sram_dq_oe0, sram_we_n0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;

  logic [15:0] mem  [0:63];
  logic [15:0] mem0 [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .st_value(st_value),
    .read_data(read_data), .ready(ready), .freeze(freeze),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .mem_r_en(mem_r_en0), .mem_w_en(mem_w_en0),
    .address(address0), .st_value(st_value0),
    .read_data(read_data0), .ready(ready0), .freeze(freeze0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_in(sram_dq_in0),
    .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0)
  );

  // Asynchronous SRAM models: combinational read, write on each strobed cycle.
  assign sram_dq_in  = mem[sram_addr[5:0]];
  assign sram_dq_in0 = mem0[sram_addr0[5:0]];

  always @(posedge clock) begin
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    if (!sram_we_n0) mem0[sram_addr0[5:0]] <= sram_dq_out0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request in the current (idle) cycle, then hold it until ready.
  // The request cycle is cycle 0.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] v, output int cycles,
                        output logic saw_oe, output logic saw_we,
                        output logic addr_moved);
    logic [17:0] start_addr;
    start_addr = sram_addr;
    mem_r_en = r; mem_w_en = w; address = a; st_value = v;
    cycles = -1; saw_oe = 1'b0; saw_we = 1'b0; addr_moved = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (sram_dq_oe) saw_oe = 1'b1;
      if (!sram_we_n) saw_we = 1'b1;
      if (sram_addr !== start_addr) addr_moved = 1'b1;
      if (ready) begin
        cycles = c;
        break;
      end
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    $display("access r=%0b w=%0b addr=%0d st=%h cycles=%0d read_data=%h",
             r, w, a, v, cycles, read_data);
  endtask

  task automatic access0(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] v, output int cycles);
    mem_r_en0 = r; mem_w_en0 = w; address0 = a; st_value0 = v;
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready0) begin
        cycles = c;
        break;
      end
    end
    mem_r_en0 = 1'b0; mem_w_en0 = 1'b0;
    $display("access0 r=%0b w=%0b addr=%0d st=%h cycles=%0d read_data=%h",
             r, w, a, v, cycles, read_data0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic        s_oe, s_we, s_mv;
    logic        oe_seen;
    logic [31:0] exp_addr, exp_data;

    reset = 1'b1;
    mem_r_en = 0; mem_w_en = 0; address = 0; st_value = 0;
    mem_r_en0 = 0; mem_w_en0 = 0; address0 = 0; st_value0 = 0;
    tick(); tick();

    // Reset state
    check("rst read_data", read_data, 32'h0);
    check("rst ready", {31'b0, ready}, 32'h0);
    check("rst sram_addr", {14'b0, sram_addr}, 32'h0);
    check("rst dq_out", {16'b0, sram_dq_out}, 32'h0);
    check("rst dq_oe", {31'b0, sram_dq_oe}, 32'h0);
    check("rst we_n", {31'b0, sram_we_n}, 32'h1);
    check("rst freeze", {31'b0, freeze}, 32'h0);
    $display("reset: read_data=%h we_n=%0b oe=%0b", read_data, sram_we_n, sram_dq_oe);
    reset = 1'b0;

    // Store DEADBEEF at 1032 -> word 2 -> half-addresses 4 and 5
    mem_w_en = 1'b1; address = 32'd1032; st_value = 32'hDEADBEEF;
    #1;
    check("store freeze c0", {31'b0, freeze}, 32'h1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 6) begin
        exp_addr = (c <= 3) ? 32'd4 : 32'd5;
        exp_data = (c <= 3) ? 32'hBEEF : 32'hDEAD;
        check($sformatf("store addr c%0d", c), {14'b0, sram_addr}, exp_addr);
        check($sformatf("store dq c%0d", c), {16'b0, sram_dq_out}, exp_data);
        check($sformatf("store we_n c%0d", c), {31'b0, sram_we_n}, 32'h0);
        check($sformatf("store oe c%0d", c), {31'b0, sram_dq_oe}, 32'h1);
        check($sformatf("store ready c%0d", c), {31'b0, ready}, 32'h0);
        check($sformatf("store freeze c%0d", c), {31'b0, freeze}, 32'h1);
      end else begin
        check("store ready c7", {31'b0, ready}, 32'h1);
        check("store freeze c7", {31'b0, freeze}, 32'h0);
        check("store we_n c7", {31'b0, sram_we_n}, 32'h1);
        check("store oe c7", {31'b0, sram_dq_oe}, 32'h0);
      end
    end
    mem_w_en = 1'b0;
    check("store mem[4]", {16'b0, mem[4]}, 32'hBEEF);
    check("store mem[5]", {16'b0, mem[5]}, 32'hDEAD);
    $display("store 1032 DEADBEEF: mem[4]=%h mem[5]=%h", mem[4], mem[5]);
    tick();

    // Load after store
    access(1'b1, 1'b0, 32'd1032, 32'h0, cyc, s_oe, s_we, s_mv);
    check("load cycles", 32'(cyc), 32'd7);
    check("load data", read_data, 32'hDEADBEEF);
    check("load oe never", {31'b0, s_oe}, 32'h0);
    check("load we never", {31'b0, s_we}, 32'h0);
    tick();

    // Both enables: the store wins and read_data is untouched
    access(1'b1, 1'b1, 32'd1024, 32'h5, cyc, s_oe, s_we, s_mv);
    check("both cycles", 32'(cyc), 32'd7);
    check("both wrote", {31'b0, s_we}, 32'h1);
    check("both read_data", read_data, 32'hDEADBEEF);
    check("both mem[0]", {16'b0, mem[0]}, 32'h5);
    check("both mem[1]", {16'b0, mem[1]}, 32'h0);
    tick();

    // Reset during the HIGH phase of a store to 1040
    mem_w_en = 1'b1; address = 32'd1040; st_value = 32'h12345678;
    tick(); tick(); tick(); tick();
    check("midrst pre we_n", {31'b0, sram_we_n}, 32'h0);
    check("midrst pre addr", {14'b0, sram_addr}, 32'd9);
    #2 reset = 1'b1;
    #1;
    check("midrst we_n", {31'b0, sram_we_n}, 32'h1);
    check("midrst oe", {31'b0, sram_dq_oe}, 32'h0);
    check("midrst ready", {31'b0, ready}, 32'h0);
    check("midrst read_data", read_data, 32'h0);
    $display("reset during HIGH: we_n=%0b oe=%0b ready=%0b", sram_we_n, sram_dq_oe, ready);
    mem_w_en = 1'b0;
    tick();
    reset = 1'b0;
    access(1'b1, 1'b0, 32'd1032, 32'h0, cyc, s_oe, s_we, s_mv);
    check("postrst cycles", 32'(cyc), 32'd7);
    check("postrst data", read_data, 32'hDEADBEEF);
    tick();

    // Repeated loads of 1028
    access(1'b0, 1'b1, 32'd1028, 32'h5555AAAA, cyc, s_oe, s_we, s_mv);
    check("st1028 cycles", 32'(cyc), 32'd7);
    tick();
    access(1'b1, 1'b0, 32'd1028, 32'h0, cyc, s_oe, s_we, s_mv);
    check("ld1028a cycles", 32'(cyc), 32'd7);
    check("ld1028a data", read_data, 32'h5555AAAA);
    tick();
    access(1'b1, 1'b0, 32'd1028, 32'h0, cyc, s_oe, s_we, s_mv);
`ifdef SRAM_READ_BUF_EN
    check("ld1028b hit cycles", 32'(cyc), 32'd1);
    check("ld1028b no addr", {31'b0, s_mv}, 32'h0);
`else
    check("ld1028b cycles", 32'(cyc), 32'd7);
`endif
    check("ld1028b data", read_data, 32'h5555AAAA);
    check("ld1028b oe", {31'b0, s_oe}, 32'h0);
    check("ld1028b we", {31'b0, s_we}, 32'h0);
    tick();
    access(1'b0, 1'b1, 32'd1028, 32'h1, cyc, s_oe, s_we, s_mv);
    check("st1028b cycles", 32'(cyc), 32'd7);
    tick();
    access(1'b1, 1'b0, 32'd1028, 32'h0, cyc, s_oe, s_we, s_mv);
`ifdef SRAM_READ_BUF_EN
    check("ld1028c hit cycles", 32'(cyc), 32'd1);
`else
    check("ld1028c cycles", 32'(cyc), 32'd7);
`endif
    check("ld1028c data", read_data, 32'h1);
    tick();

    // W=0: fill two words, then back-to-back loads
    access0(1'b0, 1'b1, 32'd1024, 32'h22221111, cyc);
    check("w0 st0 cycles", 32'(cyc), 32'd3);
    tick();
    access0(1'b0, 1'b1, 32'd1028, 32'h44443333, cyc);
    check("w0 st1 cycles", 32'(cyc), 32'd3);
    tick();
    mem_r_en0 = 1'b1; address0 = 32'd1024;
    oe_seen = 1'b0;
    tick();  // cycle 1
    check("w0 addr c1", {14'b0, sram_addr0}, 32'd0);
    if (sram_dq_oe0) oe_seen = 1'b1;
    tick();  // cycle 2
    check("w0 addr c2", {14'b0, sram_addr0}, 32'd1);
    if (sram_dq_oe0) oe_seen = 1'b1;
    tick();  // cycle 3
    check("w0 ready c3", {31'b0, ready0}, 32'h1);
    check("w0 data1", read_data0, 32'h22221111);
    $display("w0 load 1024: read_data=%h", read_data0);
    tick();  // cycle 4: second request presented in the IDLE cycle after DONE
    address0 = 32'd1028;
    #1;
    check("w0 freeze c4", {31'b0, freeze0}, 32'h1);
    tick();  // cycle 5
    check("w0 addr c5", {14'b0, sram_addr0}, 32'd2);
    tick();  // cycle 6
    check("w0 addr c6", {14'b0, sram_addr0}, 32'd3);
    check("w0 ready c6", {31'b0, ready0}, 32'h0);
    tick();  // cycle 7
    check("w0 ready c7", {31'b0, ready0}, 32'h1);
    check("w0 data2", read_data0, 32'h44443333);
    check("w0 oe never", {31'b0, oe_seen}, 32'h0);
    $display("w0 load 1028: read_data=%h", read_data0);
    mem_r_en0 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
